// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the SAR magnitude search controller.
package sar_search_pkg;

    // Default trial width; the bounds carry one extra bit so they can go negative.
    localparam int SAR_WIDTH   = 4;
    localparam int SAR_BOUND_W = SAR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } sarState_t;

    // Midpoint of the current search window; callers guarantee low <= high and low >= 0.
    function automatic int midpoint(input int low, input int high);
        return (low + high) >>> 1;
    endfunction

endpackage

// File: rtl/sar_magnitude_search.sv
// Binary-search controller that drives trial values into a magnitude comparator
// and converges on the comparator's unknown A input, one compare per clock.
module sar_magnitude_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    input  logic             cmp_greater,
    input  logic             cmp_equal,
    input  logic             cmp_less,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    // Bound registers are one bit wider and signed so trial-1 at trial=0 reads as -1.
    localparam int BW = WIDTH + 1;

    localparam logic signed [BW-1:0] BOUND_ONE  = $signed({{WIDTH{1'b0}}, 1'b1});
    localparam logic signed [BW-1:0] BOUND_MAX  = $signed({1'b0, {WIDTH{1'b1}}});
    localparam logic [WIDTH-1:0]     FIRST_TRY  = WIDTH'(midpoint(0, (1 << WIDTH) - 1));

    sarState_t               r_state;
    logic [WIDTH-1:0]        r_trial;
    logic [WIDTH-1:0]        r_result;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_found;
    logic                    r_err;
    logic signed [BW-1:0]    r_low;
    logic signed [BW-1:0]    r_high;

    logic                    w_oneHot;
    logic signed [BW-1:0]    w_trialExt;
    logic signed [BW-1:0]    w_stepLow;
    logic signed [BW-1:0]    w_stepHigh;
    logic                    w_empty;
    logic [WIDTH-1:0]        w_mid;

    // Work out the narrowed window and the next trial that a greater/less answer would give.
    always_comb begin
        w_oneHot   = ({cmp_greater, cmp_equal, cmp_less} == 3'b100) ||
                     ({cmp_greater, cmp_equal, cmp_less} == 3'b010) ||
                     ({cmp_greater, cmp_equal, cmp_less} == 3'b001);
        w_trialExt = $signed({1'b0, r_trial});
        w_stepLow  = r_low;
        w_stepHigh = r_high;
        if (cmp_greater) begin
            w_stepLow = w_trialExt + BOUND_ONE;
        end
        if (cmp_less) begin
            w_stepHigh = w_trialExt - BOUND_ONE;
        end
        w_empty = (w_stepLow > w_stepHigh);
        w_mid   = '0;
        if (!w_empty) begin
            w_mid = WIDTH'(midpoint(int'(w_stepLow), int'(w_stepHigh)));
        end
    end

    // Search FSM with all outputs registered; done is a single-cycle pulse in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_trial  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_low    <= '0;
            r_high   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state  <= EVAL;
                        r_busy   <= 1'b1;
                        r_low    <= '0;
                        r_high   <= BOUND_MAX;
                        r_trial  <= FIRST_TRY;
                        r_found  <= 1'b0;
                        r_err    <= 1'b0;
                        r_result <= '0;
                    end
                end

                EVAL: begin
                    if (!w_oneHot) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_found  <= 1'b0;
                        r_result <= '0;
                    end else if (cmp_equal) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_found  <= 1'b1;
                        r_err    <= 1'b0;
                        r_result <= r_trial;
                    end else begin
                        r_low  <= w_stepLow;
                        r_high <= w_stepHigh;
                        if (w_empty) begin
                            r_state  <= DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_found  <= 1'b0;
                            r_err    <= 1'b0;
                            r_result <= '0;
                        end else begin
                            r_trial <= w_mid;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign trial  = r_trial;
    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign found  = r_found;
    assign err    = r_err;

endmodule

// File: tb/tb_sar_magnitude_search.sv
// Directed bench for sar_magnitude_search paired with a behavioural 4-bit comparator.
module tb_sar_magnitude_search;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] trial;
    logic       cmpGreater;
    logic       cmpEqual;
    logic       cmpLess;
    logic       busy;
    logic       done;
    logic       found;
    logic       err;
    logic [3:0] result;

    logic [3:0] aValue;
    int         flagMode;
    int         assertCount;
    int         failCount;

    sar_magnitude_search #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .trial       (trial),
        .cmp_greater (cmpGreater),
        .cmp_equal   (cmpEqual),
        .cmp_less    (cmpLess),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .err         (err),
        .result      (result)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator partner: normal compare of A against trial, or forced flag patterns.
    always_comb begin
        cmpGreater = 1'b0;
        cmpEqual   = 1'b0;
        cmpLess    = 1'b0;
        case (flagMode)
            1: cmpLess = 1'b1;
            2: begin
                cmpGreater = 1'b1;
                cmpEqual   = 1'b1;
            end
            default: begin
                cmpGreater = (aValue > trial);
                cmpEqual   = (aValue == trial);
                cmpLess    = (aValue < trial);
            end
        endcase
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Run one search from IDLE and check the trial sequence, timing and final flags.
    task automatic applyStimulus(input string name, input logic [3:0] a, input int mode,
                                 input int expTrials[8], input int nCompares,
                                 input bit expFound, input int expResult, input bit expErr,
                                 input bit pokeStart);
        aValue   = a;
        flagMode = mode;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < nCompares; i++) begin
            checkOutput($sformatf("%s trial%0d", name, i), trial, expTrials[i]);
            checkOutput($sformatf("%s busy%0d", name, i), busy, 1);
            checkOutput($sformatf("%s noDone%0d", name, i), done, 0);
            if (pokeStart && i == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        checkOutput({name, " done"}, done, 1);
        checkOutput({name, " busyLow"}, busy, 0);
        checkOutput({name, " found"}, found, expFound);
        checkOutput({name, " err"}, err, expErr);
        checkOutput({name, " result"}, result, expResult);
        if (pokeStart) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({name, " donePulse"}, done, 0);
        checkOutput({name, " idleBusy"}, busy, 0);
        checkOutput({name, " heldFound"}, found, expFound);
        checkOutput({name, " heldResult"}, result, expResult);
        checkOutput({name, " heldTrial"}, trial, expTrials[nCompares-1]);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        aValue      = 4'd0;
        flagMode    = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst trial", trial, 0);
        checkOutput("rst result", result, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst found", found, 0);
        checkOutput("rst err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus("a5", 4'd5, 0, '{7, 3, 5, 0, 0, 0, 0, 0}, 3, 1'b1, 5, 1'b0, 1'b0);
        applyStimulus("a15", 4'd15, 0, '{7, 11, 13, 14, 15, 0, 0, 0}, 5, 1'b1, 15, 1'b0, 1'b1);
        applyStimulus("a0", 4'd0, 0, '{7, 3, 1, 0, 0, 0, 0, 0}, 4, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus("lessOnly", 4'd0, 1, '{7, 3, 1, 0, 0, 0, 0, 0}, 4, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus("grEq", 4'd0, 2, '{7, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b0, 0, 1'b1, 1'b0);
        applyStimulus("a10", 4'd10, 0, '{7, 11, 9, 10, 0, 0, 0, 0}, 4, 1'b1, 10, 1'b0, 1'b0);

        aValue   = 4'd15;
        flagMode = 0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("midRst preTrial", trial, 11);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midRst trial", trial, 0);
        checkOutput("midRst busy", busy, 0);
        checkOutput("midRst done", done, 0);
        checkOutput("midRst found", found, 0);
        checkOutput("midRst err", err, 0);
        checkOutput("midRst result", result, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("midRst stayIdle", busy, 0);

        applyStimulus("postRst", 4'd5, 0, '{7, 3, 5, 0, 0, 0, 0, 0}, 3, 1'b1, 5, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
